// File: rtl/prio_update_pkg.sv
// Shared types and defaults for the priority-update responder and its table.
package prio_update_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    COMMIT,
    DRAIN
  } prio_upd_state_e;

  localparam int DEF_NUM_REQ  = 32;
  localparam int DEF_PRIO_W   = 4;
  localparam int DEF_ID_W     = 5;
  localparam int DEF_RST_PRIO = 1;

  // Bit offset of entry idx inside the flat priority vector.
  function automatic int prio_slice(input int idx, input int w = DEF_PRIO_W);
    return idx * w;
  endfunction

endpackage

// File: rtl/prio_update_resp_table.sv
// prio_table_regs: per-requester priority registers with a single write port and a flat output.
module prio_table_regs
  import prio_update_pkg::*;
#(
  parameter int NUM_REQ  = DEF_NUM_REQ,
  parameter int PRIO_W   = DEF_PRIO_W,
  parameter int ID_W     = DEF_ID_W,
  parameter int RST_PRIO = DEF_RST_PRIO
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      we,
  input  logic [ID_W-1:0]           idx,
  input  logic [PRIO_W-1:0]         data,
  output logic [NUM_REQ*PRIO_W-1:0] table_q
);

  logic [PRIO_W-1:0] mem [NUM_REQ];

  // NOTE: the array is reset on purpose; the arbiter reads it directly and must
  // never see undefined weights after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REQ; i++) mem[i] <= PRIO_W'(RST_PRIO);
    end else if (we) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (idx == ID_W'(i)) mem[i] <= data;
      end
    end
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_out
    assign table_q[prio_slice(i, PRIO_W) +: PRIO_W] = mem[i];
  end

endmodule

// File: rtl/prio_update_resp.sv
// Responder side of the priority-update handshake; commits are deferred while arb_lock is high.
// Optional error reporting (upt_err, err_cnt) is enabled by PRIO_UPDATE_RESP_ERR_EN.
module prio_update_resp
  import prio_update_pkg::*;
#(
  parameter int NUM_REQ  = DEF_NUM_REQ,
  parameter int PRIO_W   = DEF_PRIO_W,
  parameter int ID_W     = DEF_ID_W,
  parameter int RST_PRIO = DEF_RST_PRIO
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      prio_upt,
  input  logic [ID_W-1:0]           prio_id,
  input  logic [PRIO_W-1:0]         prio,
  input  logic                      arb_lock,
  output logic                      ack,
  output logic [NUM_REQ*PRIO_W-1:0] prio_table,
  output logic                      upt_pulse,
  output logic                      busy
`ifdef PRIO_UPDATE_RESP_ERR_EN
  ,
  output logic                      upt_err,
  output logic [7:0]                err_cnt
`endif
);

  localparam logic [ID_W:0] NUM_REQ_L = (ID_W+1)'(NUM_REQ);

  prio_upd_state_e state_q, state_d;
  logic            commit_go;
  logic            in_range;

  assign in_range = {1'b0, prio_id} < NUM_REQ_L;

  // The table is written on the edge that enters COMMIT, so the new value and
  // ack appear together one cycle after the request is sampled.
  // NOTE: defaults first so no path through the case leaves a variable unassigned.
  always_comb begin
    state_d   = state_q;
    commit_go = 1'b0;
    case (state_q)
      IDLE: begin
        if (prio_upt) begin
          if (!arb_lock) begin
            commit_go = 1'b1;
            state_d   = COMMIT;
          end else begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (!prio_upt) begin
          state_d = IDLE;
        end else if (!arb_lock) begin
          commit_go = 1'b1;
          state_d   = COMMIT;
        end
      end
      COMMIT: state_d = DRAIN;
      DRAIN:  if (!prio_upt) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: all registered state uses non-blocking assignment so every flop sees
  // the pre-edge values of its peers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      ack       <= 1'b0;
      upt_pulse <= 1'b0;
    end else begin
      state_q   <= state_d;
      ack       <= commit_go;
      upt_pulse <= commit_go && in_range;
    end
  end

  assign busy = (state_q != IDLE);

  prio_table_regs #(
    .NUM_REQ  (NUM_REQ),
    .PRIO_W   (PRIO_W),
    .ID_W     (ID_W),
    .RST_PRIO (RST_PRIO)
  ) u_table (
    .clk     (clk),
    .rst     (rst),
    .we      (commit_go && in_range),
    .idx     (prio_id),
    .data    (prio),
    .table_q (prio_table)
  );

`ifdef PRIO_UPDATE_RESP_ERR_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      upt_err <= 1'b0;
      err_cnt <= 8'd0;
    end else begin
      upt_err <= commit_go && !in_range;
      if (commit_go && !in_range && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_prio_update_resp.sv
// Randomized self-checking bench: two responders (32 and 16 entries) share one requester.
module tb_prio_update_resp;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        prio_upt = 1'b0;
  logic [4:0]  prio_id = '0;
  logic [3:0]  prio = '0;
  logic        arb_lock = 1'b0;

  logic         ack_a, pulse_a, busy_a, ack_b, pulse_b, busy_b;
  logic [127:0] tab_a;
  logic [63:0]  tab_b;
`ifdef PRIO_UPDATE_RESP_ERR_EN
  logic       err_a, err_b;
  logic [7:0] cnt_a, cnt_b;
`endif

  always #5 clk = ~clk;

  prio_update_resp #(.NUM_REQ(32), .PRIO_W(4), .ID_W(5), .RST_PRIO(1)) dut_a (
    .clk(clk), .rst(rst), .prio_upt(prio_upt), .prio_id(prio_id), .prio(prio),
    .arb_lock(arb_lock), .ack(ack_a), .prio_table(tab_a), .upt_pulse(pulse_a), .busy(busy_a)
`ifdef PRIO_UPDATE_RESP_ERR_EN
    , .upt_err(err_a), .err_cnt(cnt_a)
`endif
  );

  prio_update_resp #(.NUM_REQ(16), .PRIO_W(4), .ID_W(5), .RST_PRIO(1)) dut_b (
    .clk(clk), .rst(rst), .prio_upt(prio_upt), .prio_id(prio_id), .prio(prio),
    .arb_lock(arb_lock), .ack(ack_b), .prio_table(tab_b), .upt_pulse(pulse_b), .busy(busy_b)
`ifdef PRIO_UPDATE_RESP_ERR_EN
    , .upt_err(err_b), .err_cnt(cnt_b)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // Reference model: a request is served once per assertion of prio_upt, only
  // while arb_lock is low; after a commit the level must be seen low at an edge
  // at least two edges later before another request can be served.
  logic [3:0] m_tab_a [32];
  logic [3:0] m_tab_b [16];
  bit m_served, m_ack, m_pulse_a, m_pulse_b, m_busy, m_err_b;
  int m_edge, m_last, m_cnt_b;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      foreach (m_tab_a[i]) m_tab_a[i] = 4'd1;
      foreach (m_tab_b[i]) m_tab_b[i] = 4'd1;
      m_served = 0; m_ack = 0; m_pulse_a = 0; m_pulse_b = 0; m_busy = 0;
      m_err_b = 0; m_cnt_b = 0; m_edge = 0; m_last = -100;
    end else begin
      bit commit;
      m_edge++;
      commit = 0;
      if (m_served) begin
        if (!prio_upt && m_edge >= m_last + 2) m_served = 0;
      end else if (prio_upt && !arb_lock) begin
        commit = 1;
        m_served = 1;
        m_last = m_edge;
      end
      m_ack     = commit;
      m_pulse_a = commit;
      m_pulse_b = commit && (prio_id < 16);
      m_err_b   = commit && (prio_id >= 16);
      if (commit) m_tab_a[prio_id] = prio;
      if (m_pulse_b) m_tab_b[prio_id[3:0]] = prio;
      if (m_err_b && m_cnt_b < 255) m_cnt_b++;
      m_busy = m_served || (prio_upt && arb_lock);
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      logic [127:0] exp_a, exp_b;
      exp_a = '0;
      exp_b = '0;
      for (int i = 0; i < 32; i++) exp_a[i*4 +: 4] = m_tab_a[i];
      for (int i = 0; i < 16; i++) exp_b[i*4 +: 4] = m_tab_b[i];
      check("ack_a", 128'(ack_a), 128'(m_ack));
      check("ack_b", 128'(ack_b), 128'(m_ack));
      check("pulse_a", 128'(pulse_a), 128'(m_pulse_a));
      check("pulse_b", 128'(pulse_b), 128'(m_pulse_b));
      check("busy_a", 128'(busy_a), 128'(m_busy));
      check("busy_b", 128'(busy_b), 128'(m_busy));
      check("table_a", tab_a, exp_a);
      check("table_b", 128'(tab_b), exp_b);
`ifdef PRIO_UPDATE_RESP_ERR_EN
      check("err_a", 128'(err_a), 128'(0));
      check("cnt_a", 128'(cnt_a), 128'(0));
      check("err_b", 128'(err_b), 128'(m_err_b));
      check("cnt_b", 128'(cnt_b), 128'(m_cnt_b));
`endif
    end
  end

  bit rand_lock = 0;

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_lock) arb_lock = ($urandom_range(0, 2) == 0);
  endtask

  task automatic release_req();
    prio_upt = 1'b0;
    repeat (2) step();
  endtask

  task automatic do_req(input logic [4:0] id, input logic [3:0] p, input int extra);
    bit got;
    got = 0;
    prio_id = id;
    prio = p;
    prio_upt = 1'b1;
    for (int i = 0; i < 80 && !got; i++) begin
      step();
      if (ack_a) got = 1;
      else if ($urandom_range(0, 19) == 0) break;
    end
    if (got) repeat (extra) step();
    release_req();
    repeat ($urandom_range(0, 2)) step();
  endtask

  logic [127:0] lit_a, lit_b;
  int acks, pulses;

  initial begin
    lit_a = {32{4'h1}};
    lit_b = {64'h0, {16{4'h1}}};
    #23 rst = 1'b1;
    step();
    check("rst_table_a", tab_a, lit_a);
    check("rst_table_b", 128'(tab_b), lit_b);
    check("rst_ack", 128'(ack_a), 128'(0));
    check("rst_pulse", 128'(pulse_a), 128'(0));
    check("rst_busy", 128'(busy_a), 128'(0));

    // Simple unlocked update.
    prio_id = 5'd5; prio = 4'd9; prio_upt = 1'b1;
    step();
    lit_a[23:20] = 4'd9;
    lit_b[23:20] = 4'd9;
    check("upd5_ack", 128'(ack_a), 128'(1));
    check("upd5_table", tab_a, lit_a);
    step();
    check("upd5_drain_ack", 128'(ack_a), 128'(0));
    check("upd5_drain_busy", 128'(busy_a), 128'(1));
    prio_upt = 1'b0;
    step();
    check("upd5_idle", 128'(busy_a), 128'(0));
    step();

    // Locked request for the top entry.
    prio_id = 5'd31; prio = 4'd15; prio_upt = 1'b1; arb_lock = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check("lock_no_ack", 128'(ack_a), 128'(0));
    end
    arb_lock = 1'b0;
    step();
    lit_a[127:124] = 4'd15;
    check("lock_ack", 128'(ack_a), 128'(1));
    check("lock_table", tab_a, lit_a);
    release_req();

    // Level held past ack: one commit only.
    prio_id = 5'd2; prio = 4'd0; prio_upt = 1'b1;
    acks = 0; pulses = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      acks += int'(ack_a);
      pulses += int'(pulse_a);
    end
    lit_a[11:8] = 4'd0;
    lit_b[11:8] = 4'd0;
    check("held_acks", 128'(acks), 128'(1));
    check("held_pulses", 128'(pulses), 128'(1));
    check("held_table", tab_a, lit_a);
    release_req();

    // Out of range on the 16-entry instance.
    prio_id = 5'd20; prio = 4'd6; prio_upt = 1'b1;
    step();
    lit_a[83:80] = 4'd6;
    check("oor_ack_b", 128'(ack_b), 128'(1));
    check("oor_pulse_b", 128'(pulse_b), 128'(0));
    check("oor_table_b", 128'(tab_b), lit_b);
    check("oor_table_a", tab_a, lit_a);
`ifdef PRIO_UPDATE_RESP_ERR_EN
    check("oor_err_b", 128'(err_b), 128'(1));
    check("oor_cnt_b", 128'(cnt_b), 128'(1));
`endif
    release_req();

    // Reset asserted while holding.
    prio_id = 5'd7; prio = 4'd3; prio_upt = 1'b1; arb_lock = 1'b1;
    repeat (2) step();
    check("hold_busy", 128'(busy_a), 128'(1));
    #2 rst = 1'b0;
    #1;
    lit_a = {32{4'h1}};
    check("mid_rst_busy", 128'(busy_a), 128'(0));
    check("mid_rst_table", tab_a, lit_a);
    #3 rst = 1'b1;
    repeat (2) begin
      step();
      check("post_rst_no_ack", 128'(ack_a), 128'(0));
    end
    release_req();
    arb_lock = 1'b0;
    prio_id = 5'd7; prio = 4'd12; prio_upt = 1'b1;
    step();
    lit_a[31:28] = 4'd12;
    check("fresh_ack", 128'(ack_a), 128'(1));
    check("fresh_table", tab_a, lit_a);
    release_req();

    // Randomized traffic with a randomly toggling lock.
    rand_lock = 1;
    for (int t = 0; t < 250; t++) begin
      do_req(5'($urandom_range(0, 31)), 4'($urandom_range(0, 15)), $urandom_range(0, 3));
    end
    rand_lock = 0;
    arb_lock = 1'b0;
    repeat (3) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
